// File: rtl/stim_gen_mc_if.sv
// ---------------------------------------------------------------------------
// stim_gen_mc_if
// Bundle between the multi-channel stimulus generator and whoever drives it
// (the logic analyzer or a testbench).
//
//   enable      run pattern generation
//   mode        pattern select: 00 counter, 01 LFSR, 10 walking-one, 11 hold
//   primed      analyzer armed, level-sensitive
//   trig_delay  cycles from primed to trigger
//   data        NUM_CH channels packed, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data_valid  data was updated on the last edge
//   trigger     one-cycle trigger pulse
//   trig_armed  trigger FSM is counting down
//
// master: the controlling side (analyzer / bench).
// slave:  the generator itself.
// ---------------------------------------------------------------------------
interface stim_gen_mc_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned TRIG_DW    = 16
);
   logic                         enable;
   logic [1:0]                   mode;
   logic                         primed;
   logic [TRIG_DW-1:0]           trig_delay;
   logic [NUM_CH*DATA_WIDTH-1:0] data;
   logic                         data_valid;
   logic                         trigger;
   logic                         trig_armed;

   modport master (
      output enable, mode, primed, trig_delay,
      input  data, data_valid, trigger, trig_armed
   );

   modport slave (
      input  enable, mode, primed, trig_delay,
      output data, data_valid, trigger, trig_armed
   );
endinterface

// File: rtl/stim_gen_mc.sv
// ---------------------------------------------------------------------------
// stim_gen_mc
// Multi-channel stimulus source for exercising the internal logic analyzer.
// Drives NUM_CH data channels in counter, LFSR, walking-one or hold mode and
// produces one trigger pulse a programmable number of cycles after the
// analyzer asserts primed.
//
// Ports:
//   clk    sole clock, all logic on posedge
//   reset  asynchronous, active-low reset
//   bus    stim_gen_mc_if.slave (enable/mode/primed/trig_delay in,
//          data/data_valid/trigger/trig_armed out)
// ---------------------------------------------------------------------------
module stim_gen_mc #(
   parameter int unsigned          DATA_WIDTH = 8,
   parameter int unsigned          NUM_CH     = 4,
   parameter int unsigned          TRIG_DW    = 16,
   parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
   input logic          clk,
   input logic          reset,
   stim_gen_mc_if.slave bus
);

   localparam logic [1:0] MODE_COUNT = 2'b00;
   localparam logic [1:0] MODE_LFSR  = 2'b01;
   localparam logic [1:0] MODE_WALK  = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_FIRE  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic                  en_q, en_d;
   logic [1:0]            mode_q, mode_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] ch_q [NUM_CH];
   logic [DATA_WIDTH-1:0] ch_d [NUM_CH];
   logic [1:0]            state_q, state_d;
   logic [TRIG_DW-1:0]    cnt_q, cnt_d;
   logic                  en_rise;

   // One Galois LFSR step: shift right, fold the taps back in when a one
   // falls off the bottom. A non-zero seed never reaches zero.
   function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH-1:0] r;
      r = v >> 1;
      if (v[0]) r = r ^ LFSR_TAPS;
      return r;
   endfunction

   // Starting value of channel k for a freshly latched mode. Hold keeps
   // whatever the channel already shows.
   function automatic logic [DATA_WIDTH-1:0] init_value(input logic [1:0] m,
                                                        input int unsigned k,
                                                        input logic [DATA_WIDTH-1:0] cur);
      logic [DATA_WIDTH-1:0] r;
      case (m)
         MODE_COUNT: r = DATA_WIDTH'(k);
         MODE_LFSR:  r = DATA_WIDTH'(k + 1);
         MODE_WALK:  r = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << (k % DATA_WIDTH);
         default:    r = cur;
      endcase
      return r;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] advance(input logic [1:0] m,
                                                     input logic [DATA_WIDTH-1:0] cur);
      logic [DATA_WIDTH-1:0] r;
      case (m)
         MODE_COUNT: r = cur + DATA_WIDTH'(1);
         MODE_LFSR:  r = lfsr_step(cur);
         MODE_WALK:  r = {cur[DATA_WIDTH-2:0], cur[DATA_WIDTH-1]};
         default:    r = cur;
      endcase
      return r;
   endfunction

   assign en_rise = bus.enable & ~en_q;

   // Pattern path. The mode input is only looked at on an enable rising
   // edge (both to pick the initial value and to latch it); from then on
   // the channels advance according to the latched mode.
   always_comb begin
      en_d    = bus.enable;
      valid_d = bus.enable;
      mode_d  = en_rise ? bus.mode : mode_q;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (en_rise)
            ch_d[k] = init_value(bus.mode, k, ch_q[k]);
         else if (bus.enable)
            ch_d[k] = advance(mode_q, ch_q[k]);
         else
            ch_d[k] = ch_q[k];
      end
   end

   // Trigger FSM. trig_delay is sampled only on ARMED entry, so later
   // changes cannot stretch or shorten a countdown already in progress.
   // DONE waits for primed to drop so each assertion fires only once.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.primed) begin
               state_d = ST_ARMED;
               cnt_d   = bus.trig_delay;
            end
         end
         ST_ARMED: begin
            if (!bus.primed)
               state_d = ST_IDLE;
            else if (cnt_q == '0)
               state_d = ST_FIRE;
            else
               cnt_d = cnt_q - TRIG_DW'(1);
         end
         ST_FIRE: state_d = ST_DONE;
         default: begin
            if (!bus.primed) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q    <= 1'b0;
         mode_q  <= MODE_COUNT;
         valid_q <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         for (int unsigned k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
      end else begin
         en_q    <= en_d;
         mode_q  <= mode_d;
         valid_q <= valid_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int unsigned k = 0; k < NUM_CH; k++) ch_q[k] <= ch_d[k];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign bus.data[g*DATA_WIDTH +: DATA_WIDTH] = ch_q[g];
   end

   assign bus.data_valid = valid_q;
   assign bus.trigger    = (state_q == ST_FIRE);
   assign bus.trig_armed = (state_q == ST_ARMED);

endmodule

// File: tb/tb_stim_gen_mc.sv
// ---------------------------------------------------------------------------
// tb_stim_gen_mc
// Self-checking bench for stim_gen_mc. Expected channel vectors are pushed to
// a queue as each enabled cycle is driven and popped when data_valid shows the
// DUT produced them; the trigger outputs are compared against an age-based
// model of the primed/trigger timing.
// ---------------------------------------------------------------------------
module tb_stim_gen_mc;

   localparam int unsigned DW  = 8;
   localparam int unsigned NCH = 4;
   localparam int unsigned TDW = 16;
   localparam logic [DW-1:0] TAPS = 8'hB8;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   stim_gen_mc_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .TRIG_DW(TDW)) bus ();

   stim_gen_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .TRIG_DW(TDW), .LFSR_TAPS(TAPS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int error_count = 0;
   int check_count = 0;
   int edge_no     = 0;

   // reference model state
   logic [DW-1:0]        m_ch [NCH];
   logic                 m_en    = 1'b0;
   logic [1:0]           m_mode  = 2'b00;
   logic                 m_valid = 1'b0;
   logic                 m_phase = 1'b0;
   int                   m_arm   = 0;
   int                   m_dly   = 0;
   logic                 exp_armed = 1'b0;
   logic                 exp_trig  = 1'b0;
   logic [NCH*DW-1:0]    exp_q [$];

   // Any hang in the flow below ends the run with a reported failure.
   initial begin
      #200us;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [DW-1:0] ch(input int k);
      return bus.data[k*DW +: DW];
   endfunction

   function automatic logic [NCH*DW-1:0] model_pack();
      logic [NCH*DW-1:0] p;
      for (int k = 0; k < NCH; k++) p[k*DW +: DW] = m_ch[k];
      return p;
   endfunction

   function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] v);
      logic lsb;
      lsb = v[0];
      v   = v >> 1;
      if (lsb) v = v ^ TAPS;
      return v;
   endfunction

   task automatic modelReset();
      for (int k = 0; k < NCH; k++) m_ch[k] = '0;
      m_en = 1'b0; m_mode = 2'b00; m_valid = 1'b0; m_phase = 1'b0;
      exp_armed = 1'b0; exp_trig = 1'b0;
      exp_q.delete();
   endtask

   // Drive one cycle of inputs on the falling edge, advance the model for
   // the following rising edge, then compare every output just after it.
   task automatic applyStimulus(input logic en, input logic [1:0] md,
                                input logic pr, input logic [TDW-1:0] dly);
      logic          rise;
      int            age;
      logic [NCH*DW-1:0] got_exp;
      @(negedge clk);
      bus.enable = en; bus.mode = md; bus.primed = pr; bus.trig_delay = dly;
      @(posedge clk);
      edge_no++;
      rise = en && !m_en;
      for (int k = 0; k < NCH; k++) begin
         if (rise) begin
            case (md)
               2'b00: m_ch[k] = DW'(k);
               2'b01: m_ch[k] = DW'(k + 1);
               2'b10: m_ch[k] = DW'(1) << (k % DW);
               default: m_ch[k] = m_ch[k];
            endcase
         end else if (en) begin
            case (m_mode)
               2'b00: m_ch[k] = m_ch[k] + 8'd1;
               2'b01: m_ch[k] = lfsr_next(m_ch[k]);
               2'b10: m_ch[k] = {m_ch[k][DW-2:0], m_ch[k][DW-1]};
               default: m_ch[k] = m_ch[k];
            endcase
         end
      end
      if (rise) m_mode = md;
      m_en    = en;
      m_valid = en;
      if (en) exp_q.push_back(model_pack());
      // Trigger timing by age since primed was first seen: ages 0..delay
      // are armed, age delay+1 fires, later ages are the wait-for-drop.
      if (!m_phase) begin
         if (pr) begin m_phase = 1'b1; m_arm = edge_no; m_dly = int'(dly); end
      end else begin
         age = edge_no - 1 - m_arm;
         if (!pr && (age <= m_dly || age > m_dly + 1)) m_phase = 1'b0;
      end
      exp_armed = m_phase && ((edge_no - m_arm) <= m_dly);
      exp_trig  = m_phase && ((edge_no - m_arm) == m_dly + 1);
      #1;
      checkOutput("data_valid", 64'(bus.data_valid), 64'(m_valid));
      if (m_valid) begin
         checkOutput("sb_depth", 64'(exp_q.size()), 64'd1);
         if (exp_q.size() > 0) begin
            got_exp = exp_q.pop_front();
            checkOutput("data_sb", 64'(bus.data), 64'(got_exp));
         end
      end else begin
         checkOutput("data_hold", 64'(bus.data), 64'(model_pack()));
      end
      checkOutput("trig_armed", 64'(bus.trig_armed), 64'(exp_armed));
      checkOutput("trigger", 64'(bus.trigger), 64'(exp_trig));
   endtask

   // Assert reset between clock edges and look at the outputs before any
   // edge can occur; release just after a rising edge so the next modelled
   // edge is the first one the DUT sees out of reset.
   task automatic midCycleReset();
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      checkOutput("rst_data", 64'(bus.data), 64'd0);
      checkOutput("rst_valid", 64'(bus.data_valid), 64'd0);
      checkOutput("rst_trigger", 64'(bus.trigger), 64'd0);
      checkOutput("rst_armed", 64'(bus.trig_armed), 64'd0);
      modelReset();
      @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] prev3, prev0, first0;
      int wrap_step, zero_seen, collisions, period, trig_seen;

      bus.enable = 1'b0; bus.mode = 2'b00; bus.primed = 1'b0; bus.trig_delay = '0;
      modelReset();

      // reset state
      #12;
      checkOutput("init_data", 64'(bus.data), 64'd0);
      checkOutput("init_valid", 64'(bus.data_valid), 64'd0);
      checkOutput("init_trigger", 64'(bus.trigger), 64'd0);
      checkOutput("init_armed", 64'(bus.trig_armed), 64'd0);
      @(posedge clk);
      #2;
      reset = 1'b1;

      // counter mode
      applyStimulus(1, 2'b00, 0, 0);
      for (int k = 0; k < NCH; k++) checkOutput("cnt_init", 64'(ch(k)), 64'(k));
      applyStimulus(1, 2'b00, 0, 0);
      for (int k = 0; k < NCH; k++) checkOutput("cnt_step1", 64'(ch(k)), 64'(k + 1));
      wrap_step = -1;
      for (int i = 2; i <= 260; i++) begin
         prev3 = ch(3);
         applyStimulus(1, 2'b00, 0, 0);
         if (prev3 == 8'hFF && ch(3) == 8'h00 && wrap_step < 0) wrap_step = i;
      end
      checkOutput("cnt_ch3_wrap_step", 64'(wrap_step), 64'd253);
      applyStimulus(0, 2'b00, 0, 0);
      applyStimulus(0, 2'b00, 0, 0);

      // LFSR mode
      applyStimulus(1, 2'b01, 0, 0);
      first0 = ch(0);
      checkOutput("lfsr_init_ch0", 64'(first0), 64'h01);
      checkOutput("lfsr_init_ch3", 64'(ch(3)), 64'h04);
      zero_seen = 0; collisions = 0; period = -1;
      for (int i = 1; i <= 300; i++) begin
         applyStimulus(1, 2'b00, 0, 0);
         if (i == 1) checkOutput("lfsr_step1", 64'(ch(0)), 64'hB8);
         if (i == 2) checkOutput("lfsr_step2", 64'(ch(0)), 64'h5C);
         for (int k = 0; k < NCH; k++) if (ch(k) == 8'h00) zero_seen++;
         for (int a = 0; a < NCH; a++)
            for (int b = a + 1; b < NCH; b++) if (ch(a) == ch(b)) collisions++;
         if (ch(0) == first0 && period < 0) period = i;
      end
      checkOutput("lfsr_no_zero", 64'(zero_seen), 64'd0);
      checkOutput("lfsr_distinct", 64'(collisions), 64'd0);
      checkOutput("lfsr_period", 64'(period), 64'd255);
      applyStimulus(0, 2'b01, 0, 0);

      // walking-one mode, then a mode change that must be ignored
      applyStimulus(1, 2'b10, 0, 0);
      checkOutput("walk_ch0_init", 64'(ch(0)), 64'h01);
      checkOutput("walk_ch2_init", 64'(ch(2)), 64'h04);
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1, 2'b10, 0, 0);
         checkOutput("walk_ch0_rot", 64'(ch(0)), 64'(DW'(1) << (i % DW)));
      end
      for (int i = 9; i <= 11; i++) applyStimulus(1, 2'b00, 0, 0);
      checkOutput("walk_mode_ignored", 64'(ch(0)), 64'h08);
      applyStimulus(0, 2'b00, 0, 0);
      checkOutput("walk_disabled_hold", 64'(ch(0)), 64'h08);
      applyStimulus(1, 2'b00, 0, 0);
      checkOutput("relatch_ch0", 64'(ch(0)), 64'h00);
      checkOutput("relatch_ch3", 64'(ch(3)), 64'h03);

      // trigger, delay 5, counter running alongside; later trig_delay ignored
      for (int i = 0; i < 3; i++) applyStimulus(1, 2'b00, 0, 5);
      applyStimulus(1, 2'b00, 1, 5);
      checkOutput("t5_armed_e0", 64'(bus.trig_armed), 64'd1);
      checkOutput("t5_trig_e0", 64'(bus.trigger), 64'd0);
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1, 2'b00, 1, 9);
         checkOutput("t5_armed", 64'(bus.trig_armed), 64'(i <= 5));
         checkOutput("t5_trig", 64'(bus.trigger), 64'(i == 6));
      end
      trig_seen = 0;
      for (int i = 0; i < 50; i++) begin
         applyStimulus(0, 2'b00, 1, 9);
         if (bus.trigger) trig_seen++;
      end
      checkOutput("t5_single_pulse", 64'(trig_seen), 64'd0);
      applyStimulus(0, 2'b00, 0, 0);

      // trigger, delay 0
      applyStimulus(0, 2'b00, 1, 0);
      checkOutput("t0_armed", 64'(bus.trig_armed), 64'd1);
      applyStimulus(0, 2'b00, 1, 0);
      checkOutput("t0_trig", 64'(bus.trigger), 64'd1);
      applyStimulus(0, 2'b00, 1, 0);
      checkOutput("t0_trig_off", 64'(bus.trigger), 64'd0);
      applyStimulus(0, 2'b00, 0, 0);

      // abort: delay 20 with primed dropped after 8 cycles
      trig_seen = 0;
      for (int i = 0; i < 8; i++) applyStimulus(0, 2'b00, 1, 20);
      for (int i = 0; i < 30; i++) begin
         applyStimulus(0, 2'b00, 0, 20);
         if (bus.trigger || bus.trig_armed) trig_seen++;
      end
      checkOutput("abort_quiet", 64'(trig_seen), 64'd0);
      applyStimulus(0, 2'b00, 1, 0);
      applyStimulus(0, 2'b00, 1, 0);
      checkOutput("abort_back_idle", 64'(bus.trigger), 64'd1);
      applyStimulus(0, 2'b00, 0, 0);

      // reset in the middle of a countdown and an LFSR run
      applyStimulus(0, 2'b00, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 2'b01, 1, 20);
      midCycleReset();
      applyStimulus(1, 2'b01, 1, 3);
      checkOutput("rearm_after_reset", 64'(bus.trig_armed), 64'd1);
      checkOutput("reload_after_reset", 64'(ch(1)), 64'h02);
      for (int i = 0; i < 6; i++) applyStimulus(1, 2'b01, 1, 3);
      applyStimulus(0, 2'b00, 0, 0);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
